// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg -- shared types for the hsv core commit slice.
//   reg_addr_t / word_t  : register address (5) and data word (32)
//   commit_data_t        : one unit's result presented to commit
//   unit_e / NUM_UNITS   : the result-producing units; the enum value is the
//                          bit index of that unit in valid/grant vectors
//   commit_state_e       : commit FSM states, exported for debug
package hsv_core_pkg;

  localparam int NUM_UNITS = 5;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_addr_t rd_addr;
    word_t     rd_value;
    logic      writeback;
    logic      trap;
  } commit_data_t;

  typedef enum logic [2:0] {
    UNIT_ALU         = 3'd0,
    UNIT_FOO         = 3'd1,
    UNIT_MEM         = 3'd2,
    UNIT_BRANCH      = 3'd3,
    UNIT_CTRL_STATUS = 3'd4
  } unit_e;

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_FLUSH_WAIT = 1'b1
  } commit_state_e;

endpackage

// File: rtl/hsv_core_commit_if.sv
// hsv_core_commit_if -- all non-clock signals of the commit stage.
//   Per unit u in {alu, foo, mem, branch, ctrl_status}:
//     <u>_commit_data, <u>_valid_i  (producer -> commit)
//     <u>_ready_o                   (commit -> producer)
//   Register-file side: wr_addr, wr_data, wr_en, commit_mask (commit -> core)
//   Flush: flush_req (commit -> core), flush_ack (core -> commit)
// Handshake: a result moves when <u>_valid_i and <u>_ready_o are both high on
// a rising clock edge; the producer holds valid and data stable until then,
// and ready never depends on anything but valids, FSM state and reset.
// modport master = producers/core side, modport slave = commit block.
interface hsv_core_commit_if;
  import hsv_core_pkg::*;

  commit_data_t alu_commit_data;
  logic         alu_valid_i;
  logic         alu_ready_o;
  commit_data_t foo_commit_data;
  logic         foo_valid_i;
  logic         foo_ready_o;
  commit_data_t mem_commit_data;
  logic         mem_valid_i;
  logic         mem_ready_o;
  commit_data_t branch_commit_data;
  logic         branch_valid_i;
  logic         branch_ready_o;
  commit_data_t ctrl_status_commit_data;
  logic         ctrl_status_valid_i;
  logic         ctrl_status_ready_o;

  reg_addr_t    wr_addr;
  word_t        wr_data;
  logic         wr_en;
  logic [31:0]  commit_mask;
  logic         flush_req;
  logic         flush_ack;

  modport master (
    output alu_commit_data, alu_valid_i, foo_commit_data, foo_valid_i,
           mem_commit_data, mem_valid_i, branch_commit_data, branch_valid_i,
           ctrl_status_commit_data, ctrl_status_valid_i, flush_ack,
    input  alu_ready_o, foo_ready_o, mem_ready_o, branch_ready_o,
           ctrl_status_ready_o, wr_addr, wr_data, wr_en, commit_mask, flush_req
  );

  modport slave (
    input  alu_commit_data, alu_valid_i, foo_commit_data, foo_valid_i,
           mem_commit_data, mem_valid_i, branch_commit_data, branch_valid_i,
           ctrl_status_commit_data, ctrl_status_valid_i, flush_ack,
    output alu_ready_o, foo_ready_o, mem_ready_o, branch_ready_o,
           ctrl_status_ready_o, wr_addr, wr_data, wr_en, commit_mask, flush_req
  );

endinterface

// File: rtl/hsv_core_commit_arbiter.sv
// hsv_core_commit_arbiter -- picks one unit result per cycle.
//   clk, rst_n : clock / async active-low reset (pointer state only)
//   valid      : request vector, bit index = unit_e
//   grant      : one-hot grant, zero when no request
// Build option HSV_COMMIT_ROUND_ROBIN_EN: round-robin starting at alu, the
// pointer moving to the unit after each grantee. Default: fixed priority
// ctrl_status > branch > mem > alu > foo, with no state at all.
module hsv_core_commit_arbiter
  import hsv_core_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_UNITS-1:0] valid,
  output logic [NUM_UNITS-1:0] grant
);

`ifdef HSV_COMMIT_ROUND_ROBIN_EN
  logic [2:0] ptr_q;
  logic [2:0] grant_idx;
  logic [2:0] idx;
  logic [3:0] sum;
  logic       found;

  // Scan from the pointer, wrapping modulo NUM_UNITS.
  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    found     = 1'b0;
    idx       = '0;
    sum       = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      sum = {1'b0, ptr_q} + 4'(k);
      idx = (sum >= 4'(NUM_UNITS)) ? 3'(sum - 4'(NUM_UNITS)) : sum[2:0];
      if (!found && valid[idx]) begin
        found       = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 3'(UNIT_ALU);
    end else if (found) begin
      ptr_q <= (grant_idx == 3'(NUM_UNITS - 1)) ? 3'd0 : grant_idx + 3'd1;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    grant = '0;
    if      (valid[UNIT_CTRL_STATUS]) grant[UNIT_CTRL_STATUS] = 1'b1;
    else if (valid[UNIT_BRANCH])      grant[UNIT_BRANCH]      = 1'b1;
    else if (valid[UNIT_MEM])         grant[UNIT_MEM]         = 1'b1;
    else if (valid[UNIT_ALU])         grant[UNIT_ALU]         = 1'b1;
    else if (valid[UNIT_FOO])         grant[UNIT_FOO]         = 1'b1;
  end
`endif

endmodule

// File: rtl/hsv_core_commit.sv
// hsv_core_commit -- retires unit results into the register file.
//   clk_core, rst_core_n : core clock, async active-low reset
//   cif (slave)          : unit results/handshakes, register-file write
//                          port, commit_mask and flush_req/flush_ack
//   state_dbg            : current FSM state (RUN / FLUSH_WAIT)
// One result is accepted per cycle; its write appears one cycle later.
// A trapping result suppresses its write and parks the block in FLUSH_WAIT
// (no grants, flush_req high) until flush_ack is sampled high.
// Arbitration policy is chosen by HSV_COMMIT_ROUND_ROBIN_EN in the arbiter.
module hsv_core_commit
  import hsv_core_pkg::*;
(
  input  logic            clk_core,
  input  logic            rst_core_n,
  hsv_core_commit_if.slave cif,
  output commit_state_e   state_dbg
);

  commit_state_e          state_q, state_d;
  logic [NUM_UNITS-1:0]   valid_vec, grant;
  commit_data_t           unit_data [NUM_UNITS];
  commit_data_t           sel;
  logic                   xfer, do_write, grant_en;

  assign valid_vec[UNIT_ALU]         = cif.alu_valid_i;
  assign valid_vec[UNIT_FOO]         = cif.foo_valid_i;
  assign valid_vec[UNIT_MEM]         = cif.mem_valid_i;
  assign valid_vec[UNIT_BRANCH]      = cif.branch_valid_i;
  assign valid_vec[UNIT_CTRL_STATUS] = cif.ctrl_status_valid_i;

  assign unit_data[UNIT_ALU]         = cif.alu_commit_data;
  assign unit_data[UNIT_FOO]         = cif.foo_commit_data;
  assign unit_data[UNIT_MEM]         = cif.mem_commit_data;
  assign unit_data[UNIT_BRANCH]      = cif.branch_commit_data;
  assign unit_data[UNIT_CTRL_STATUS] = cif.ctrl_status_commit_data;

  // Reset is folded in so readies drop the instant reset asserts.
  assign grant_en = (state_q == ST_RUN) && rst_core_n;

  hsv_core_commit_arbiter u_arbiter (
    .clk   (clk_core),
    .rst_n (rst_core_n),
    .valid (valid_vec & {NUM_UNITS{grant_en}}),
    .grant (grant)
  );

  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (grant[k]) sel = unit_data[k];
    end
  end

  assign xfer     = |grant;
  assign do_write = xfer && !sel.trap && sel.writeback && (sel.rd_addr != '0);

  // FSM: state register
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) state_q <= ST_RUN;
    else             state_q <= state_d;
  end

  // FSM: next state (flush_ack only matters in FLUSH_WAIT)
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:        if (xfer && sel.trap) state_d = ST_FLUSH_WAIT;
      ST_FLUSH_WAIT: if (cif.flush_ack)    state_d = ST_RUN;
      default:       state_d = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cif.flush_req           = (state_q == ST_FLUSH_WAIT);
    cif.alu_ready_o         = grant[UNIT_ALU];
    cif.foo_ready_o         = grant[UNIT_FOO];
    cif.mem_ready_o         = grant[UNIT_MEM];
    cif.branch_ready_o      = grant[UNIT_BRANCH];
    cif.ctrl_status_ready_o = grant[UNIT_CTRL_STATUS];
    state_dbg               = state_q;
  end

  // Write port: strobe/mask pulse for one cycle, address/data hold.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      cif.wr_en       <= 1'b0;
      cif.wr_addr     <= '0;
      cif.wr_data     <= '0;
      cif.commit_mask <= '0;
    end else begin
      cif.wr_en       <= do_write;
      cif.commit_mask <= do_write ? (32'd1 << sel.rd_addr) : 32'd0;
      if (do_write) begin
        cif.wr_addr <= sel.rd_addr;
        cif.wr_data <= sel.rd_value;
      end
    end
  end

endmodule

// File: tb/tb_hsv_core_commit.sv
module tb_hsv_core_commit;
  import hsv_core_pkg::*;

  logic          clk_core = 1'b0;
  logic          rst_core_n;
  commit_state_e state_dbg;
  int            checks = 0;
  int            errors = 0;

  hsv_core_commit_if cif ();

  hsv_core_commit dut (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .cif        (cif.slave),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clk_core = ~clk_core;

  function automatic commit_data_t mk(input logic [4:0] rd, input logic [31:0] val,
                                      input logic wb, input logic trap);
    commit_data_t d;
    d.rd_addr = rd; d.rd_value = val; d.writeback = wb; d.trap = trap;
    return d;
  endfunction

  function automatic logic [4:0] rdy();
    return {cif.ctrl_status_ready_o, cif.branch_ready_o, cif.mem_ready_o,
            cif.foo_ready_o, cif.alu_ready_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cycle();
    @(posedge clk_core);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_wr_en"}, 32'(cif.wr_en), 32'd1);
    check({tag, "_wr_addr"}, 32'(cif.wr_addr), 32'(a));
    check({tag, "_wr_data"}, cif.wr_data, d);
    check({tag, "_mask"}, cif.commit_mask, 32'd1 << a);
  endtask

  task automatic clear_valids();
    cif.alu_valid_i = 1'b0; cif.foo_valid_i = 1'b0; cif.mem_valid_i = 1'b0;
    cif.branch_valid_i = 1'b0; cif.ctrl_status_valid_i = 1'b0;
  endtask

  initial begin
    rst_core_n = 1'b0;
    clear_valids();
    cif.flush_ack = 1'b0;
    cif.alu_commit_data = '0; cif.foo_commit_data = '0; cif.mem_commit_data = '0;
    cif.branch_commit_data = '0; cif.ctrl_status_commit_data = '0;

    // reset state, with a valid unit that must not be granted
    cif.alu_valid_i = 1'b1;
    cif.alu_commit_data = mk(5'd5, 32'h1111_1111, 1'b1, 1'b0);
    #2;
    check("rst_ready", 32'(rdy()), 32'h0);
    check("rst_wr_en", 32'(cif.wr_en), 32'h0);
    check("rst_wr_addr", 32'(cif.wr_addr), 32'h0);
    check("rst_wr_data", cif.wr_data, 32'h0);
    check("rst_mask", cif.commit_mask, 32'h0);
    check("rst_flush", 32'(cif.flush_req), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_RUN));
    cif.alu_valid_i = 1'b0;
    cycle(); cycle();
    rst_core_n = 1'b1;
    cycle();

    // single alu write
    cif.alu_valid_i = 1'b1;
    cif.alu_commit_data = mk(5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    #1 check("alu_ready", 32'(rdy()), 32'b00001);
    cycle();
    cif.alu_valid_i = 1'b0;
    check_write("alu", 5'd5, 32'hDEAD_BEEF);
    check("alu_mask_val", cif.commit_mask, 32'h20);
    cycle();
    check("idle_wr_en", 32'(cif.wr_en), 32'h0);
    check("idle_mask", cif.commit_mask, 32'h0);
    check("idle_hold_addr", 32'(cif.wr_addr), 32'd5);

    // mem to r0 retires silently
    cif.mem_valid_i = 1'b1;
    cif.mem_commit_data = mk(5'd0, 32'h0BAD_F00D, 1'b1, 1'b0);
    #1 check("mem_ready", 32'(rdy()), 32'b00100);
    cycle();
    cif.mem_valid_i = 1'b0;
    check("r0_wr_en", 32'(cif.wr_en), 32'h0);
    check("r0_mask", cif.commit_mask, 32'h0);
    check("r0_hold_data", cif.wr_data, 32'hDEAD_BEEF);

    // writeback=0 retires silently
    cif.foo_valid_i = 1'b1;
    cif.foo_commit_data = mk(5'd9, 32'h9999_0000, 1'b0, 1'b0);
    #1 check("nowb_ready", 32'(rdy()), 32'b00010);
    cycle();
    cif.foo_valid_i = 1'b0;
    check("nowb_wr_en", 32'(cif.wr_en), 32'h0);
    check("nowb_mask", cif.commit_mask, 32'h0);

    // fixed priority: ctrl_status, branch, alu back to back
    cif.alu_valid_i = 1'b1;         cif.alu_commit_data = mk(5'd1, 32'h11, 1'b1, 1'b0);
    cif.branch_valid_i = 1'b1;      cif.branch_commit_data = mk(5'd2, 32'h22, 1'b1, 1'b0);
    cif.ctrl_status_valid_i = 1'b1; cif.ctrl_status_commit_data = mk(5'd3, 32'h33, 1'b1, 1'b0);
`ifndef HSV_COMMIT_ROUND_ROBIN_EN
    #1 check("pri_g0", 32'(rdy()), 32'b10000);
    cycle(); cif.ctrl_status_valid_i = 1'b0;
    check_write("pri_w0", 5'd3, 32'h33);
    #1 check("pri_g1", 32'(rdy()), 32'b01000);
    cycle(); cif.branch_valid_i = 1'b0;
    check_write("pri_w1", 5'd2, 32'h22);
    #1 check("pri_g2", 32'(rdy()), 32'b00001);
    cycle(); cif.alu_valid_i = 1'b0;
    check_write("pri_w2", 5'd1, 32'h11);
`else
    // pointer sits after foo, so mem is skipped and branch comes first
    #1 check("rr3_g0", 32'(rdy()), 32'b01000);
    cycle(); cif.branch_valid_i = 1'b0;
    check_write("rr3_w0", 5'd2, 32'h22);
    #1 check("rr3_g1", 32'(rdy()), 32'b10000);
    cycle(); cif.ctrl_status_valid_i = 1'b0;
    check_write("rr3_w1", 5'd3, 32'h33);
    #1 check("rr3_g2", 32'(rdy()), 32'b00001);
    cycle(); cif.alu_valid_i = 1'b0;
    check_write("rr3_w2", 5'd1, 32'h11);
`endif
    cycle();
    check("pri_end_wr_en", 32'(cif.wr_en), 32'h0);

    // flush_ack ignored in RUN
    cif.flush_ack = 1'b1;
    cycle();
    cif.flush_ack = 1'b0;
    check("ack_run_flush", 32'(cif.flush_req), 32'h0);
    check("ack_run_state", 32'(state_dbg), 32'(ST_RUN));

    // branch trap -> flush handshake
    cif.branch_valid_i = 1'b1;
    cif.branch_commit_data = mk(5'd4, 32'h4444_4444, 1'b1, 1'b1);
    #1 check("trap_ready", 32'(rdy()), 32'b01000);
    cycle();
    cif.branch_valid_i = 1'b0;
    check("trap_flush", 32'(cif.flush_req), 32'h1);
    check("trap_wr_en", 32'(cif.wr_en), 32'h0);
    check("trap_mask", cif.commit_mask, 32'h0);
    check("trap_state", 32'(state_dbg), 32'(ST_FLUSH_WAIT));
    cif.alu_valid_i = 1'b1;
    cif.alu_commit_data = mk(5'd6, 32'h6666_0006, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("fw_ready", 32'(rdy()), 32'h0);
      cycle();
      check("fw_flush_hold", 32'(cif.flush_req), 32'h1);
    end
    cif.flush_ack = 1'b1;
    cycle();
    cif.flush_ack = 1'b0;
    check("ack_flush", 32'(cif.flush_req), 32'h0);
    #1 check("resume_ready", 32'(rdy()), 32'b00001);
    cycle();
    cif.alu_valid_i = 1'b0;
    check_write("resume", 5'd6, 32'h6666_0006);

    // reset discards a pending write
    cif.mem_valid_i = 1'b1;
    cif.mem_commit_data = mk(5'd9, 32'h0000_0099, 1'b1, 1'b0);
    cycle();
    cif.mem_valid_i = 1'b0;
    check("pend_wr_en", 32'(cif.wr_en), 32'h1);
    #2 rst_core_n = 1'b0;
    #1;
    check("pend_rst_wr_en", 32'(cif.wr_en), 32'h0);
    check("pend_rst_addr", 32'(cif.wr_addr), 32'h0);
    cycle();
    rst_core_n = 1'b1;
    cycle();

    // reset during FLUSH_WAIT drops flush_req at once
    cif.ctrl_status_valid_i = 1'b1;
    cif.ctrl_status_commit_data = mk(5'd7, 32'h7, 1'b1, 1'b1);
    cycle();
    cif.ctrl_status_valid_i = 1'b0;
    check("trap2_flush", 32'(cif.flush_req), 32'h1);
    #2 rst_core_n = 1'b0;
    #1;
    check("fwrst_flush", 32'(cif.flush_req), 32'h0);
    check("fwrst_wr_en", 32'(cif.wr_en), 32'h0);
    check("fwrst_state", 32'(state_dbg), 32'(ST_RUN));
    cycle();
    rst_core_n = 1'b1;
    cycle();

    // all five valid
    cif.alu_valid_i = 1'b1;         cif.alu_commit_data = mk(5'd10, 32'hA0, 1'b1, 1'b0);
    cif.foo_valid_i = 1'b1;         cif.foo_commit_data = mk(5'd11, 32'hA1, 1'b1, 1'b0);
    cif.mem_valid_i = 1'b1;         cif.mem_commit_data = mk(5'd12, 32'hA2, 1'b1, 1'b0);
    cif.branch_valid_i = 1'b1;      cif.branch_commit_data = mk(5'd13, 32'hA3, 1'b1, 1'b0);
    cif.ctrl_status_valid_i = 1'b1; cif.ctrl_status_commit_data = mk(5'd14, 32'hA4, 1'b1, 1'b0);
`ifdef HSV_COMMIT_ROUND_ROBIN_EN
    // held continuously; pointer starts at alu after reset
    #1 check("rr_g0", 32'(rdy()), 32'b00001);
    cycle(); check_write("rr_w0", 5'd10, 32'hA0);
    #1 check("rr_g1", 32'(rdy()), 32'b00010);
    cycle(); check_write("rr_w1", 5'd11, 32'hA1);
    #1 check("rr_g2", 32'(rdy()), 32'b00100);
    cycle(); check_write("rr_w2", 5'd12, 32'hA2);
    #1 check("rr_g3", 32'(rdy()), 32'b01000);
    cycle(); check_write("rr_w3", 5'd13, 32'hA3);
    #1 check("rr_g4", 32'(rdy()), 32'b10000);
    cycle(); check_write("rr_w4", 5'd14, 32'hA4);
    #1 check("rr_g5", 32'(rdy()), 32'b00001);
`else
    // each producer drops after its grant: full priority chain incl. alu > foo
    #1 check("all_g0", 32'(rdy()), 32'b10000);
    cycle(); cif.ctrl_status_valid_i = 1'b0; check_write("all_w0", 5'd14, 32'hA4);
    #1 check("all_g1", 32'(rdy()), 32'b01000);
    cycle(); cif.branch_valid_i = 1'b0; check_write("all_w1", 5'd13, 32'hA3);
    #1 check("all_g2", 32'(rdy()), 32'b00100);
    cycle(); cif.mem_valid_i = 1'b0; check_write("all_w2", 5'd12, 32'hA2);
    #1 check("all_g3", 32'(rdy()), 32'b00001);
    cycle(); cif.alu_valid_i = 1'b0; check_write("all_w3", 5'd10, 32'hA0);
    #1 check("all_g4", 32'(rdy()), 32'b00010);
    cycle(); cif.foo_valid_i = 1'b0; check_write("all_w4", 5'd11, 32'hA1);
`endif
    clear_valids();
    #1 check("final_ready", 32'(rdy()), 32'h0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
